aes_selftest_seq: RTL and testbench
===================================

// Module: aes_selftest_seq
// PURPOSE
// - Parametrised encrypt/decrypt self-test sequencer. Successor to the fixed single-vector top-level controller.
// - On start, walks NUM_VECTORS plaintexts from an external vector ROM. For each vector it requests encryption,
//   then decryption of the returned cipher, from a shared AES core via a valid/ready handshake.
// - Compares the round-trip plaintext, counts pass/fail, applies a per-request timeout, and shows a selected
//   result byte in decimal on NUM_DIGITS seven-segment digits.
// PARAMETERS
// - NUM_VECTORS  4    plaintext vectors per run (1..256)
// - DISP_BYTE    15   byte of 128-bit result shown; 15 = bits [7:0], 0 = bits [127:120]
// - NUM_DIGITS   3    seven-segment digits (>=3; extra high digits show 0)
// - TIMEOUT_CYC  64   max cycles from req accept to rsp_valid before abort (>=2)
// PORTS
// - clk              in   1             rising-edge clock
// - reset            in   1             synchronous, active-high
// - start            in   1             1-cycle pulse; starts a run when idle
// - key_mode         in   2             00=128, 01=192, 10=256; 11 illegal -> run aborts fail
// - vec_idx          out  clog2(NV)     vector ROM address
// - vec_plain        in   128           ROM data; valid 1 cycle after vec_idx changes
// - req_valid        out  1             core request valid
// - req_ready        in   1             core accepts when req_valid & req_ready
// - req_decrypt      out  1             0=encrypt, 1=decrypt
// - req_mode         out  2             key_mode latched at start
// - req_data         out  128           plaintext or cipher
// - rsp_valid        in   1             core result strobe, 1 cycle
// - rsp_data         in   128           core result
// - busy             out  1             high from start-accept until DONE
// - done             out  1             held high in DONE until next start or reset
// - all_pass         out  1             valid with done: fail_cnt==0 and no abort
// - is_match         out  1             last checked vector matched
// - pass_cnt         out  9             vectors passed this run
// - fail_cnt         out  9             vectors failed (mismatch, timeout, illegal mode)
// - seg_out          out  7*NUM_DIGITS  active-low gfedcba; digit 0 = units at [6:0]
// BEHAVIOUR
// - Reset: FSM IDLE; vec_idx=0; req_valid=0; req_decrypt=0; req_mode=0; req_data=0; busy=0; done=0;
//   all_pass=0; is_match=0; counters=0; seg_out all 1s (blank). Reset mid-run drops req_valid next edge;
//   responses arriving later are ignored.
// - FSM:
//   - IDLE -start-> LOAD: latch key_mode; clear counters and done; vec_idx=0.
//   - If key_mode==11: -> DONE with fail_cnt=1, all_pass=0.
//   - LOAD (1 cycle): capture vec_plain -> ENC_REQ.
//   - ENC_REQ: req_valid=1, req_decrypt=0, req_data=plain; hold stable until ready -> ENC_WAIT.
//   - ENC_WAIT: on rsp_valid: latch cipher, update display -> DEC_REQ.
//   - DEC_REQ: as ENC_REQ with req_decrypt=1, req_data=cipher -> DEC_WAIT.
//   - DEC_WAIT: on rsp_valid: latch result, update display -> CHECK.
//   - CHECK: is_match=(result==plain); bump pass_cnt or fail_cnt.
//     Then -> LOAD with vec_idx+1, or -> DONE if vec_idx==NUM_VECTORS-1 (no wrap).
//   - DONE: busy=0, done=1, all_pass computed; start -> LOAD (new run).
// - Timeout: counter cleared on accept, increments in *_WAIT. At TIMEOUT_CYC with no rsp_valid:
//   fail_cnt+1, is_match=0, run aborts to DONE, all_pass=0.
//   rsp_valid in the same cycle as expiry wins (no timeout).
// - start while busy or in LOAD ignored; key_mode changes mid-run ignored.
// - rsp_valid outside *_WAIT ignored.
// - Display: 1 cycle after each accepted response, seg_out shows decimal value (0..255) of byte DISP_BYTE
//   of rsp_data; digit codes: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//   7=1111000 8=0000000 9=0010000. Held until next response or reset.
// - Counters saturate at 511. No combinational path from inputs to outputs.
// STRUCTURE
// - Package aes_pkg: MODE_128/192/256 constants, FSM state encoding, digit-to-segment table.
// - One sub-module bin_to_7seg #(IN_W=8, NUM_DIGITS): combinational double-dabble BCD conversion plus
//   segment decode; output registered in parent.
// TESTING
// - 128, NV=1, model core returns 3ad77bb40d7a3660a89ecaf32466ef97 for 6bc1bee22e409f96e93d7e117393172a:
//   seg shows 151, then 042; done, all_pass=1, pass_cnt=1.
// - 256, NV=4, model core with random 0-5 cycle ready/rsp delays: 4 passes, req_data stable while
//   req_valid & !req_ready.
// - Core corrupts decrypt bit 0 on vector 2: is_match=0 after that CHECK, fail_cnt=1, pass_cnt=3, all_pass=0.
// - Core never answers encrypt: abort at TIMEOUT_CYC=64 cycles after accept, done=1, fail_cnt=1.
//   Also rsp_valid on the expiry cycle -> no timeout.
// - key_mode=11 -> done within 2 cycles, fail_cnt=1. Reset in DEC_WAIT -> all outputs at reset values
//   next cycle, late rsp_valid ignored.
// - start pulsed while busy and during DONE: ignored / restarts run with counters cleared.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants for the AES self-test sequencer: key modes, FSM states
// and the seven-segment digit table.
package aes_pkg;

  localparam logic [1:0] MODE_128 = 2'b00;
  localparam logic [1:0] MODE_192 = 2'b01;
  localparam logic [1:0] MODE_256 = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;

  localparam int CNT_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ENC_REQ,
    ST_ENC_WAIT,
    ST_DEC_REQ,
    ST_DEC_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Active-low gfedcba segment pattern for one decimal digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bin_to_7seg.sv
// Combinational binary-to-decimal conversion (double dabble) followed by
// per-digit seven-segment decode; the caller registers the result.
module bin_to_7seg
  import aes_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic [IN_W-1:0]         bin,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int BCD_W = 4 * NUM_DIGITS;

  logic [BCD_W-1:0] bcd;

  always_comb begin
    bcd = '0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (bcd[4*d +: 4] >= 4'd5) begin
          bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
        end
      end
      bcd = {bcd[BCD_W-2:0], bin[i]};
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign seg[7*gi +: 7] = seg_decode(bcd[4*gi +: 4]);
    end
  endgenerate

endmodule

// File: rtl/aes_selftest_seq.sv
// Encrypt/decrypt round-trip self-test sequencer: walks a vector ROM through a
// shared AES core, counts pass/fail, and shows one result byte in decimal.
module aes_selftest_seq
  import aes_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int DISP_BYTE   = 15,
  parameter int NUM_DIGITS  = 3,
  parameter int TIMEOUT_CYC = 64,
  localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              key_mode,
  output logic [IDX_W-1:0]        vec_idx,
  input  logic [127:0]            vec_plain,
  output logic                    req_valid,
  input  logic                    req_ready,
  output logic                    req_decrypt,
  output logic [1:0]              req_mode,
  output logic [127:0]            req_data,
  input  logic                    rsp_valid,
  input  logic [127:0]            rsp_data,
  output logic                    busy,
  output logic                    done,
  output logic                    all_pass,
  output logic                    is_match,
  output logic [8:0]              pass_cnt,
  output logic [8:0]              fail_cnt,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam int DISP_LSB = (15 - DISP_BYTE) * 8;

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg;
  logic [1:0]              mode_reg;
  logic [127:0]            plain_reg, cipher_reg, result_reg;
  logic [TMO_W-1:0]        tmo_reg;
  logic [CNT_W-1:0]        pass_reg, fail_reg;
  logic                    match_reg;
  logic [7*NUM_DIGITS-1:0] seg_reg, seg_next;
  logic                    tmo_expired;

  assign tmo_expired = (tmo_reg == TMO_LAST);

  bin_to_7seg #(
    .IN_W       (8),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_disp (
    .bin (rsp_data[DISP_LSB +: 8]),
    .seg (seg_next)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) state_next = (key_mode == MODE_BAD) ? ST_DONE : ST_LOAD;
      end
      ST_LOAD:     state_next = ST_ENC_REQ;
      ST_ENC_REQ:  if (req_ready) state_next = ST_ENC_WAIT;
      ST_ENC_WAIT: begin
        if (rsp_valid)        state_next = ST_DEC_REQ;
        else if (tmo_expired) state_next = ST_DONE;
      end
      ST_DEC_REQ:  if (req_ready) state_next = ST_DEC_WAIT;
      ST_DEC_WAIT: begin
        if (rsp_valid)        state_next = ST_CHECK;
        else if (tmo_expired) state_next = ST_DONE;
      end
      ST_CHECK:    state_next = (idx_reg == LAST_IDX) ? ST_DONE : ST_LOAD;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      mode_reg   <= '0;
      plain_reg  <= '0;
      cipher_reg <= '0;
      result_reg <= '0;
      tmo_reg    <= '0;
      pass_reg   <= '0;
      fail_reg   <= '0;
      match_reg  <= 1'b0;
      seg_reg    <= '1;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mode_reg  <= key_mode;
            idx_reg   <= '0;
            pass_reg  <= '0;
            fail_reg  <= (key_mode == MODE_BAD) ? CNT_W'(1) : '0;
            match_reg <= 1'b0;
          end
        end
        ST_LOAD: plain_reg <= vec_plain;
        // Holding the timer at zero while requesting makes it zero on accept.
        ST_ENC_REQ, ST_DEC_REQ: tmo_reg <= '0;
        ST_ENC_WAIT, ST_DEC_WAIT: begin
          if (rsp_valid) begin
            if (state_reg == ST_ENC_WAIT) cipher_reg <= rsp_data;
            else                          result_reg <= rsp_data;
            seg_reg <= seg_next;
          end else if (tmo_expired) begin
            fail_reg  <= sat_inc(fail_reg);
            match_reg <= 1'b0;
          end else begin
            tmo_reg <= tmo_reg + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          match_reg <= (result_reg == plain_reg);
          if (result_reg == plain_reg) pass_reg <= sat_inc(pass_reg);
          else                         fail_reg <= sat_inc(fail_reg);
          if (idx_reg != LAST_IDX) idx_reg <= idx_reg + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign vec_idx     = idx_reg;
  assign req_valid   = (state_reg == ST_ENC_REQ) || (state_reg == ST_DEC_REQ);
  assign req_decrypt = (state_reg == ST_DEC_REQ);
  assign req_mode    = mode_reg;
  assign req_data    = (state_reg == ST_ENC_REQ) ? plain_reg :
                       (state_reg == ST_DEC_REQ) ? cipher_reg : '0;
  assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done        = (state_reg == ST_DONE);
  assign all_pass    = (state_reg == ST_DONE) && (fail_reg == '0);
  assign is_match    = match_reg;
  assign pass_cnt    = pass_reg;
  assign fail_cnt    = fail_reg;
  assign seg_out     = seg_reg;

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Self-checking bench for aes_selftest_seq: a behavioural AES core model with
// a request scoreboard, table-driven runs and hand-written corner sequences.
module tb_aes_selftest_seq;
  import aes_pkg::*;

  localparam int NV  = 4;
  localparam int ND  = 3;
  localparam int TMO = 64;
  localparam logic [127:0] KP   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] KC   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] MASK = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start;
  logic [1:0]    key_mode;
  logic [1:0]    vec_idx;
  logic [127:0]  vec_plain;
  logic          req_valid, req_ready, req_decrypt;
  logic [1:0]    req_mode;
  logic [127:0]  req_data;
  logic          rsp_valid;
  logic [127:0]  rsp_data;
  logic          busy, done, all_pass, is_match;
  logic [8:0]    pass_cnt, fail_cnt;
  logic [7*ND-1:0] seg_out;

  logic [127:0] rom [NV];
  assign vec_plain = rom[vec_idx];

  bit           core_en;
  logic         core_ready, core_rsp_valid, man_ready, man_rsp_valid;
  logic [127:0] core_rsp_data, man_rsp_data;
  assign req_ready = core_en ? core_ready : man_ready;
  assign rsp_valid = core_en ? core_rsp_valid : man_rsp_valid;
  assign rsp_data  = core_en ? core_rsp_data : man_rsp_data;

  aes_selftest_seq #(
    .NUM_VECTORS (NV),
    .DISP_BYTE   (15),
    .NUM_DIGITS  (ND),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .key_mode    (key_mode),
    .vec_idx     (vec_idx),
    .vec_plain   (vec_plain),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_decrypt (req_decrypt),
    .req_mode    (req_mode),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .done        (done),
    .all_pass    (all_pass),
    .is_match    (is_match),
    .pass_cnt    (pass_cnt),
    .fail_cnt    (fail_cnt),
    .seg_out     (seg_out)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // Behavioural core: a fixed known-answer pair, otherwise a reversible mask.
  function automatic logic [127:0] model_enc(input logic [127:0] p);
    return (p == KP) ? KC : (p ^ MASK);
  endfunction
  function automatic logic [127:0] model_dec(input logic [127:0] c);
    return (c == KC) ? KP : (c ^ MASK);
  endfunction

  function automatic logic [20:0] seg_of(input int v);
    logic [6:0] t [10];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
          7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return {t[(v / 100) % 10], t[(v / 10) % 10], t[v % 10]};
  endfunction

  typedef struct {
    logic         dec;
    logic [127:0] data;
  } req_t;
  req_t        exp_q[$];
  logic [1:0]  exp_mode;
  logic [20:0] seg_hist[$];
  int max_rdy, max_rsp, enc_fix, corrupt_idx, dec_count, acc_cyc;
  bit no_answer_enc;

  initial begin
    logic [127:0] held, res;
    logic hdec, bad;
    int d, r;
    req_t e;
    core_ready = 1'b0;
    core_rsp_valid = 1'b0;
    core_rsp_data = '0;
    forever begin
      @(negedge clk);
      if (core_en && req_valid) begin
        held = req_data;
        hdec = req_decrypt;
        d = $urandom_range(max_rdy, 0);
        repeat (d) begin
          @(negedge clk);
          check("req_hold_valid", {127'd0, req_valid}, 128'd1);
          check("req_hold_data", req_data, held);
        end
        core_ready = 1'b1;
        @(negedge clk);
        core_ready = 1'b0;
        acc_cyc = cyc;
        $display("txn %s mode=%0d data=%h", hdec ? "dec" : "enc", req_mode, held);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got request %h, required none", held);
        end else begin
          e = exp_q.pop_front();
          check("req_decrypt", {127'd0, hdec}, {127'd0, e.dec});
          check("req_data", held, e.data);
          check("req_mode", {126'd0, req_mode}, {126'd0, exp_mode});
        end
        if (!(no_answer_enc && !hdec)) begin
          r = (!hdec && enc_fix >= 0) ? enc_fix : $urandom_range(max_rsp, 0);
          repeat (r) @(negedge clk);
          res = hdec ? model_dec(held) : model_enc(held);
          bad = hdec && (dec_count == corrupt_idx);
          if (bad) res[0] = ~res[0];
          core_rsp_valid = 1'b1;
          core_rsp_data = res;
          @(negedge clk);
          core_rsp_valid = 1'b0;
          check("seg_after_rsp", {107'd0, seg_out}, {107'd0, seg_of(int'(res[7:0]))});
          seg_hist.push_back(seg_out);
          if (hdec) begin
            @(negedge clk);
            check("is_match_after_check", {127'd0, is_match}, {127'd0, !bad});
            dec_count++;
          end
        end
      end
    end
  end

  task automatic pulse_start(input logic [1:0] m);
    key_mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int used);
    used = 0;
    while (!done && used < budget) begin
      @(negedge clk);
      used++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL wait_done: done=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic wait_req(input int budget);
    int n = 0;
    while (!req_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!req_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_req: req_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {127'd0, busy}, 128'd0);
    check({tag, "_done"}, {127'd0, done}, 128'd0);
    check({tag, "_req_valid"}, {127'd0, req_valid}, 128'd0);
    check({tag, "_req_decrypt"}, {127'd0, req_decrypt}, 128'd0);
    check({tag, "_req_mode"}, {126'd0, req_mode}, 128'd0);
    check({tag, "_req_data"}, req_data, 128'd0);
    check({tag, "_all_pass"}, {127'd0, all_pass}, 128'd0);
    check({tag, "_is_match"}, {127'd0, is_match}, 128'd0);
    check({tag, "_pass_cnt"}, {119'd0, pass_cnt}, 128'd0);
    check({tag, "_fail_cnt"}, {119'd0, fail_cnt}, 128'd0);
    check({tag, "_vec_idx"}, {126'd0, vec_idx}, 128'd0);
    check({tag, "_seg_out"}, {107'd0, seg_out}, {107'd0, 21'h1fffff});
  endtask

  task automatic fill_rom(input bit known);
    for (int i = 0; i < NV; i++) rom[i] = {$urandom, $urandom, $urandom, $urandom};
    if (known) rom[0] = KP;
  endtask

  typedef struct {
    logic [1:0] mode;
    bit         known;
    int         rdy;
    int         rsp;
    int         corrupt;
    int         efix;
    bit         mid_start;
    int         e_pass;
    int         e_fail;
    bit         e_all;
    bit         e_last;
  } row_t;
  row_t rows[5];

  task automatic run_row(input row_t rw);
    int used;
    fill_rom(rw.known);
    max_rdy = rw.rdy;
    max_rsp = rw.rsp;
    enc_fix = rw.efix;
    corrupt_idx = rw.corrupt;
    dec_count = 0;
    exp_mode = rw.mode;
    exp_q.delete();
    seg_hist.delete();
    for (int i = 0; i < NV; i++) begin
      exp_q.push_back('{1'b0, rom[i]});
      exp_q.push_back('{1'b1, model_enc(rom[i])});
    end
    pulse_start(rw.mode);
    check("busy_after_start", {127'd0, busy}, 128'd1);
    check("done_cleared", {127'd0, done}, 128'd0);
    check("pass_cleared", {119'd0, pass_cnt}, 128'd0);
    check("fail_cleared", {119'd0, fail_cnt}, 128'd0);
    if (rw.mid_start) begin
      repeat (6) @(negedge clk);
      pulse_start(MODE_BAD);
      key_mode = MODE_192;
      check("busy_after_mid_start", {127'd0, busy}, 128'd1);
    end
    wait_done(4000, used);
    repeat (2) @(negedge clk);
    check("run_pass_cnt", {119'd0, pass_cnt}, 128'(rw.e_pass));
    check("run_fail_cnt", {119'd0, fail_cnt}, 128'(rw.e_fail));
    check("run_all_pass", {127'd0, all_pass}, {127'd0, rw.e_all});
    check("run_last_match", {127'd0, is_match}, {127'd0, rw.e_last});
    check("run_busy_low", {127'd0, busy}, 128'd0);
    check("run_reqs_left", 128'(exp_q.size()), 128'd0);
    if (rw.known) begin
      check("seg_hist_len", 128'(seg_hist.size()), 128'(2 * NV));
      if (seg_hist.size() >= 2) begin
        check("seg_enc_151", {107'd0, seg_hist[0]}, {107'd0, seg_of(151)});
        check("seg_dec_042", {107'd0, seg_hist[1]}, {107'd0, seg_of(42)});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int used;
    rows[0] = '{MODE_128, 1'b1, 0, 0, -1, -1, 1'b0, 4, 0, 1'b1, 1'b1};
    rows[1] = '{MODE_256, 1'b0, 5, 5, -1, -1, 1'b1, 4, 0, 1'b1, 1'b1};
    rows[2] = '{MODE_256, 1'b0, 5, 5,  2, -1, 1'b0, 3, 1, 1'b0, 1'b1};
    rows[3] = '{MODE_192, 1'b0, 2, 3,  3, -1, 1'b0, 3, 1, 1'b0, 1'b0};
    rows[4] = '{MODE_128, 1'b0, 3, 3, -1, TMO - 1, 1'b0, 4, 0, 1'b1, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    key_mode = 2'b00;
    core_en = 1'b1;
    man_ready = 1'b0;
    man_rsp_valid = 1'b0;
    man_rsp_data = '0;
    max_rdy = 0;
    max_rsp = 0;
    enc_fix = -1;
    corrupt_idx = -1;
    no_answer_enc = 1'b0;
    for (int i = 0; i < NV; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("por");

    for (int k = 0; k < 5; k++) run_row(rows[k]);

    // Encrypt request accepted but never answered: abort exactly at the timeout.
    fill_rom(1'b0);
    exp_q.delete();
    exp_q.push_back('{1'b0, rom[0]});
    exp_mode = MODE_192;
    max_rdy = 2;
    enc_fix = -1;
    corrupt_idx = -1;
    no_answer_enc = 1'b1;
    pulse_start(MODE_192);
    wait_done(300, used);
    check("timeout_latency", 128'(cyc - acc_cyc), 128'(TMO));
    check("timeout_fail_cnt", {119'd0, fail_cnt}, 128'd1);
    check("timeout_pass_cnt", {119'd0, pass_cnt}, 128'd0);
    check("timeout_all_pass", {127'd0, all_pass}, 128'd0);
    check("timeout_is_match", {127'd0, is_match}, 128'd0);
    no_answer_enc = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);

    // Illegal key mode aborts straight to done.
    pulse_start(MODE_BAD);
    wait_done(2, used);
    check("illegal_done", {127'd0, done}, 128'd1);
    check("illegal_fail_cnt", {119'd0, fail_cnt}, 128'd1);
    check("illegal_pass_cnt", {119'd0, pass_cnt}, 128'd0);
    check("illegal_all_pass", {127'd0, all_pass}, 128'd0);
    check("illegal_busy", {127'd0, busy}, 128'd0);
    repeat (2) @(negedge clk);

    // Reset while waiting for the decrypt response, then a stale response.
    core_en = 1'b0;
    fill_rom(1'b0);
    pulse_start(MODE_128);
    wait_req(20);
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    man_rsp_valid = 1'b1;
    man_rsp_data = model_enc(rom[0]);
    @(negedge clk);
    man_rsp_valid = 1'b0;
    wait_req(20);
    check("manual_dec_req", {127'd0, req_decrypt}, 128'd1);
    check("manual_dec_data", req_data, model_enc(rom[0]));
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    @(negedge clk);
    check("manual_busy_in_wait", {127'd0, busy}, 128'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
    man_rsp_valid = 1'b1;
    man_rsp_data = rom[0];
    @(negedge clk);
    man_rsp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("late_rsp");
    core_en = 1'b1;

    run_row(rows[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
